// File: rtl/if_queue_if.sv
// Fetch-to-decode queue bus: push side from fetch, head/handshake side toward decode.
// The slave modport is the queue; the master modport is whatever drives fetch/decode.
interface if_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PTR_W = 2
);
    logic             push_valid_i;
    logic [XLEN-1:0]  push_pc_i;
    logic [31:0]      push_inst_i;
    logic             push_ready_o;
    logic             flush_i;
    logic             id_ready_i;
    logic             id_valid_o;
    logic [XLEN-1:0]  id_pc_o;
    logic [31:0]      id_inst_o;
    logic [PTR_W:0]   count_o;

    modport master (
        output push_valid_i, push_pc_i, push_inst_i, flush_i, id_ready_i,
        input  push_ready_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );

    modport slave (
        input  push_valid_i, push_pc_i, push_inst_i, flush_i, id_ready_i,
        output push_ready_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );
endinterface

// File: rtl/if_queue.sv
// Instruction fetch queue: DEPTH-entry circular FIFO of {pc, inst} pairs between fetch and
// decode, flushed wholesale on any control-flow redirect.
module if_queue #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_W    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic        clk,
    input logic        rst,
    if_queue_if.slave  q
);
    localparam int unsigned EntW = XLEN + 32;
    localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

    logic [EntW-1:0]  mem_q [DEPTH];
    logic [EntW-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic            empty, full, id_valid, push_fire, pop_fire;
    logic [EntW-1:0] head;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DepthCnt);
    assign id_valid  = !empty && !q.flush_i;
    // Ready depends on count only; a full queue never accepts, even alongside a pop.
    assign push_fire = q.push_valid_i && !full && !q.flush_i;
    assign pop_fire  = id_valid && q.id_ready_i;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) begin
                mem_d[wr_ptr_q] = {q.push_pc_i, q.push_inst_i};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign q.push_ready_o = !full;
    assign q.id_valid_o   = id_valid;
    assign q.id_pc_o      = empty ? '0 : head[EntW-1:32];
    assign q.id_inst_o    = empty ? NOP_INST : head[31:0];
    assign q.count_o      = count_q;
endmodule

// File: tb/tb_if_queue.sv
// Scoreboard bench for if_queue: directed scenarios then random traffic against a
// queue-based reference model; a separate monitor checks every entry decode consumes.
module tb_if_queue;
    localparam int unsigned Depth = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_queue_if #(.XLEN(32), .PTR_W(2)) bus ();

    if_queue #(
        .XLEN(32),
        .DEPTH(Depth),
        .PTR_W(2),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q(bus.slave)
    );

    ent_t mq[$];  // model contents
    ent_t sb[$];  // expected outputs toward decode
    int   checks = 0;
    int   errors = 0;
    bit   checks_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake decode sees must match the next expected entry.
    always @(negedge clk) begin
        if (checks_on && bus.id_valid_o === 1'b1 && bus.id_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 32'd1, 32'd0);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("pop_pc", bus.id_pc_o, e.pc);
                chk("pop_inst", bus.id_inst_o, e.inst);
            end
        end
    end

    // One clock of stimulus: drive, check status at negedge, commit model at posedge.
    task automatic cycle(input bit pv, input logic [31:0] pc, input logic [31:0] inst,
                         input bit rdy, input bit fl, input bit r);
        bit   push_ok, pop_ok;
        ent_t e;
        rst              = r;
        bus.push_valid_i = pv;
        bus.push_pc_i    = pc;
        bus.push_inst_i  = inst;
        bus.id_ready_i   = rdy;
        bus.flush_i      = fl;
        push_ok = pv && !fl && (mq.size() < Depth);
        pop_ok  = rdy && !fl && (mq.size() > 0);
        @(negedge clk);
        if (checks_on) begin
            chk("count", 32'(bus.count_o), 32'(mq.size()));
            chk("push_ready", 32'(bus.push_ready_o), 32'(mq.size() != Depth));
            chk("id_valid", 32'(bus.id_valid_o), 32'(mq.size() != 0 && !fl));
            if (mq.size() == 0) begin
                chk("empty_pc", bus.id_pc_o, 32'h0);
                chk("empty_inst", bus.id_inst_o, 32'h0000_0013);
            end
        end
        @(posedge clk);
        if (r || fl) begin
            mq.delete();
            sb.delete();
        end else begin
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) begin
                e.pc   = pc;
                e.inst = inst;
                mq.push_back(e);
                sb.push_back(e);
            end
        end
        if (r) checks_on = 1'b1;
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        bus.push_valid_i = 1'b0;
        bus.push_pc_i    = '0;
        bus.push_inst_i  = '0;
        bus.id_ready_i   = 1'b0;
        bus.flush_i      = 1'b0;
        @(posedge clk);
        #1;

        // Reset then idle
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // Single push then pop
        cycle(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
        chk("single_pc", bus.id_pc_o, 32'h100);
        chk("single_inst", bus.id_inst_o, 32'h0050_0093);
        idle(1'b1);
        idle(1'b0);

        // Fill and back-pressure, then drain
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(bus.count_o), 32'd4);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Wrap-around with simultaneous push and pop
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Flush with simultaneous push
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h40 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h200, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-operation with push and pop
        for (int i = 0; i < 2; i++) cycle(1'b1, 32'h80 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h300, 32'h0000_0300, 1'b1, 1'b0, 1'b1);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, $urandom & 32'hffff_fffc, $urandom,
                  ($urandom % 3) != 0, ($urandom % 25) == 0, ($urandom % 80) == 0);
        end

        // Drain and confirm every expected entry was delivered
        for (int i = 0; i < Depth + 2; i++) idle(1'b1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
